regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 16x32 register file.
- Width, register count and read-port count are configurable.
- Two write ports: ALU result and load writeback.
- Optional same-cycle write-to-read bypass.
- Adds a pending-load scoreboard with an outstanding-load limit, and the PC sequencer held in the top register index.
- Sits in the datapath between decode/issue and execute/memory writeback; the controller uses the busy flags for load-use stalls.

Parameters:
- DATA_W, 32, register data width.
- NUM_REGS, 16, register count; index NUM_REGS-1 is the PC. Derived AW = clog2(NUM_REGS).
- PC_W, 7, PC width; PC_W <= DATA_W.
- NUM_RD, 4, combinational read ports.
- BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads see stored value only.
- MAX_PEND, 4, maximum outstanding loads, 1..NUM_REGS-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_data1  in  DATA_W  ALU write data.
- w_addr1  in  AW  ALU write address.
- w_en1  in  1  ALU write enable.
- w_data_ldr  in  DATA_W  load writeback data.
- w_addr_ldr  in  AW  load writeback address.
- w_en_ldr  in  1  load writeback enable.
- ldr_issue  in  1  load issued; marks target register pending.
- ldr_issue_addr  in  AW  target register of the issued load.
- issue_ready  out  1  high when pend_cnt < MAX_PEND.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  port i reads a register with a pending load.
- sel_pc  in  2  PC source select.
- load_pc  in  1  PC update enable.
- start_pc  in  PC_W  start address.
- dp_pc  in  PC_W  branch target from datapath.
- pc_out  out  PC_W  current PC.
- pend_cnt  out  clog2(MAX_PEND+1)  number of outstanding loads.
- sb_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): all GPRs=0, pc=0, busy bits=0, pend_cnt=0, sb_err=0. Consequently issue_ready=1 and rd_busy=0. The same state holds while rst_n is low mid-operation; in-flight loads are forgotten.
- Writes (sequential):
  - Writes addressed to index NUM_REGS-1 are ignored on both ports.
  - w_en1 and w_en_ldr to the same address in one cycle: load data wins.
- Reads (combinational):
  - Address NUM_REGS-1 returns the PC zero-extended to DATA_W.
  - BYPASS=1: a port addressing a register written this cycle returns the write data (load data if both ports write it). Otherwise the port returns the stored value.
  - BYPASS=0: stored value only.
- Scoreboard: one busy bit per GPR.
  - Accepted issue: ldr_issue=1 and issue_ready=1 and target != PC and target not busy. Sets busy[target] next edge; pend_cnt+1.
  - Errors (no scoreboard change, sb_err set until reset):
    - Issue to an already-busy register.
    - Issue while issue_ready=0.
    - Issue to the PC index.
  - Load writeback clear: w_en_ldr=1 with busy[w_addr_ldr]=1 clears the bit; pend_cnt-1.
  - w_en_ldr to a non-busy register writes the data; no scoreboard change, no error.
  - Same-cycle accepted issue and clear, different registers: one bit set, one bit cleared, pend_cnt unchanged.
  - Same-cycle issue and clear, same register: the clear takes effect, then the issue is evaluated against the cleared bit. Net result: bit stays set, pend_cnt unchanged, data written.
  - w_en1 to a busy register writes data and leaves the bit set; the later load data overwrites it.
  - rd_busy[i] = busy[rd_addr_i]. With BYPASS=1, rd_busy[i] is masked to 0 when the same-cycle load writeback clears that register. rd_busy for the PC index is always 0.
- PC, on edge with load_pc=1:
  - sel_pc=01: pc <= start_pc.
  - sel_pc=11: pc <= dp_pc.
  - sel_pc=00 or 10: pc <= pc+1, wrapping mod 2^PC_W.
  - load_pc=0: PC holds.
- Latency: write-to-read 1 cycle, or 0 with BYPASS. Busy bits visible the cycle after issue.

Test Plan:
- Reset, then write R3=0xDEADBEEF via port 1 → next cycle all four read ports addressing R3 return 0xDEADBEEF. Writing R15=5 leaves port reads of R15 at zero-extended pc=0.
- Same cycle: w_en1 R2=0x11 and w_en_ldr R2=0x22 → R2=0x22. With BYPASS=1, a same-cycle read of R2 returns 0x22; with BYPASS=0 it returns the old value 0.
- MAX_PEND=4: issue loads to R1..R4 on 4 consecutive cycles → pend_cnt=4, issue_ready=0, rd_busy set for reads of R1..R4. A 5th issue to R5 → ignored, sb_err=1. Writeback of R2 → pend_cnt=3, issue_ready=1.
- Busy R6, same cycle: writeback R6=0x77 and issue R6 → R6=0x77, busy[R6] stays 1, pend_cnt unchanged, sb_err=0.
- PC sequencing: load_pc with sel_pc=01 and start_pc=0x7E → pc=0x7E. Two increments → 0x7F, then 0x00. sel_pc=11 with dp_pc=0x10 → 0x10. load_pc=0 → pc holds.
- Assert rst_n low mid-operation with 3 loads pending and sb_err=1 → immediately pend_cnt=0, rd_busy=0, sb_err=0, pc=0, all reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two write ports (ALU and load
// writeback), NUM_RD combinational read ports with optional same-cycle bypass,
// a pending-load scoreboard with an outstanding-load limit, and the PC
// sequencer mapped onto the top register index.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int PC_W     = 7,
   parameter int NUM_RD   = 4,
   parameter int BYPASS   = 1,
   parameter int MAX_PEND = 4,
   localparam int AW      = $clog2(NUM_REGS),
   localparam int CW      = $clog2(MAX_PEND + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        w_data1,
   input  logic [AW-1:0]            w_addr1,
   input  logic                     w_en1,
   input  logic [DATA_W-1:0]        w_data_ldr,
   input  logic [AW-1:0]            w_addr_ldr,
   input  logic                     w_en_ldr,
   input  logic                     ldr_issue,
   input  logic [AW-1:0]            ldr_issue_addr,
   output logic                     issue_ready,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [1:0]               sel_pc,
   input  logic                     load_pc,
   input  logic [PC_W-1:0]          start_pc,
   input  logic [PC_W-1:0]          dp_pc,
   output logic [PC_W-1:0]          pc_out,
   output logic [CW-1:0]            pend_cnt,
   output logic                     sb_err
);

   localparam int            PC_IDX = NUM_REGS - 1;
   // Storage spans the full address space so any AW-bit index is in range;
   // entries at or above the PC index are never written and read as zero.
   localparam int            NADDR  = 1 << AW;
   localparam logic [AW-1:0] PC_A   = AW'(PC_IDX);

   logic [DATA_W-1:0] gpr_q [NADDR];
   logic [DATA_W-1:0] gpr_d [NADDR];
   logic [NADDR-1:0]  busy_q;
   logic [NADDR-1:0]  busy_d;
   logic [NADDR-1:0]  busy_clr;
   logic [CW-1:0]     pend_q;
   logic [CW-1:0]     pend_d;
   logic              err_q;
   logic              err_d;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;

   logic              wr1_ok;
   logic              wrl_ok;
   logic              ld_clr;
   logic              iss_to_pc;
   logic              iss_ok;
   logic              iss_err;
   logic [AW-1:0]     rd_a [NUM_RD];

   assign issue_ready = (pend_q < CW'(MAX_PEND));
   assign pend_cnt    = pend_q;
   assign sb_err      = err_q;
   assign pc_out      = pc_q;

   // Qualify writes (PC index is read-only here) and build next GPR contents; load data wins a tie.
   always_comb begin
      wr1_ok = w_en1 && (w_addr1 < PC_A);
      wrl_ok = w_en_ldr && (w_addr_ldr < PC_A);
      gpr_d  = gpr_q;
      if (wr1_ok) begin
         gpr_d[w_addr1] = w_data1;
      end
      if (wrl_ok) begin
         gpr_d[w_addr_ldr] = w_data_ldr;
      end
   end

   // Scoreboard: apply the writeback clear first, then judge the issue against the cleared bits.
   always_comb begin
      ld_clr   = wrl_ok && busy_q[w_addr_ldr];
      busy_clr = busy_q;
      if (ld_clr) begin
         busy_clr[w_addr_ldr] = 1'b0;
      end
      iss_to_pc = !(ldr_issue_addr < PC_A);
      iss_ok    = ldr_issue && issue_ready && !iss_to_pc && !busy_clr[ldr_issue_addr];
      iss_err   = ldr_issue && !iss_ok;
      busy_d    = busy_clr;
      if (iss_ok) begin
         busy_d[ldr_issue_addr] = 1'b1;
      end
      pend_d = pend_q + CW'(iss_ok) - CW'(ld_clr);
      err_d  = err_q | iss_err;
   end

   // PC sequencer: load start address, take branch target, or increment with natural wrap.
   always_comb begin
      pc_d = pc_q;
      if (load_pc) begin
         case (sel_pc)
            2'b01:   pc_d = start_pc;
            2'b11:   pc_d = dp_pc;
            default: pc_d = pc_q + PC_W'(1);
         endcase
      end
   end

   // Read ports: PC index returns the zero-extended PC; otherwise stored value, optionally bypassed.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_a[i] = rd_addr[i*AW +: AW];
         if (rd_a[i] == PC_A) begin
            rd_data[i*DATA_W +: DATA_W] = DATA_W'(pc_q);
         end else begin
            rd_data[i*DATA_W +: DATA_W] = gpr_q[rd_a[i]];
            if (BYPASS != 0) begin
               if (wrl_ok && (w_addr_ldr == rd_a[i])) begin
                  rd_data[i*DATA_W +: DATA_W] = w_data_ldr;
               end else if (wr1_ok && (w_addr1 == rd_a[i])) begin
                  rd_data[i*DATA_W +: DATA_W] = w_data1;
               end
            end
            // A load landing this cycle already satisfies the dependency when bypassing.
            rd_busy[i] = busy_q[rd_a[i]] &&
                         !((BYPASS != 0) && ld_clr && (w_addr_ldr == rd_a[i]));
         end
      end
   end

   // State register: async clear forgets all in-flight loads, errors, PC and register contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NADDR; r++) begin
            gpr_q[r] <= '0;
         end
         busy_q <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
         pc_q   <= '0;
      end else begin
         gpr_q  <= gpr_d;
         busy_q <= busy_d;
         pend_q <= pend_d;
         err_q  <= err_d;
         pc_q   <= pc_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized stimulus for regfile_sb, with one
// bypassing and one non-bypassing instance driven from the same inputs and
// compared against a behavioural model of registers, busy flags and PC.
module tb_regfile_sb;

   localparam int            DW  = 32;
   localparam int            NR  = 16;
   localparam int            AW  = 4;
   localparam int            PW  = 7;
   localparam int            NRD = 4;
   localparam int            MP  = 4;
   localparam int            CW  = 3;
   localparam logic [AW-1:0] PCA = 4'd15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     w_data1;
   logic [AW-1:0]     w_addr1;
   logic              w_en1;
   logic [DW-1:0]     w_data_ldr;
   logic [AW-1:0]     w_addr_ldr;
   logic              w_en_ldr;
   logic              ldr_issue;
   logic [AW-1:0]     ldr_issue_addr;
   logic [NRD*AW-1:0] rd_addr;
   logic [1:0]        sel_pc;
   logic              load_pc;
   logic [PW-1:0]     start_pc;
   logic [PW-1:0]     dp_pc;

   logic              issue_ready_b, issue_ready_n;
   logic [NRD*DW-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]    rd_busy_b, rd_busy_n;
   logic [PW-1:0]     pc_out_b, pc_out_n;
   logic [CW-1:0]     pend_cnt_b, pend_cnt_n;
   logic              sb_err_b, sb_err_n;

   // behavioural model state
   logic [DW-1:0]     m_reg [NR];
   bit                m_busy [NR];
   int                m_pend;
   bit                m_err;
   logic [PW-1:0]     m_pc;

   int                n_chk  = 0;
   int                n_pass = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .PC_W(PW), .NUM_RD(NRD), .BYPASS(1), .MAX_PEND(MP)) u_dut_byp (
      .clk(clk), .rst_n(rst_n),
      .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
      .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
      .ldr_issue(ldr_issue), .ldr_issue_addr(ldr_issue_addr), .issue_ready(issue_ready_b),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .sel_pc(sel_pc), .load_pc(load_pc), .start_pc(start_pc), .dp_pc(dp_pc),
      .pc_out(pc_out_b), .pend_cnt(pend_cnt_b), .sb_err(sb_err_b)
   );

   regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .PC_W(PW), .NUM_RD(NRD), .BYPASS(0), .MAX_PEND(MP)) u_dut_nb (
      .clk(clk), .rst_n(rst_n),
      .w_data1(w_data1), .w_addr1(w_addr1), .w_en1(w_en1),
      .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
      .ldr_issue(ldr_issue), .ldr_issue_addr(ldr_issue_addr), .issue_ready(issue_ready_n),
      .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .sel_pc(sel_pc), .load_pc(load_pc), .start_pc(start_pc), .dp_pc(dp_pc),
      .pc_out(pc_out_n), .pend_cnt(pend_cnt_n), .sb_err(sb_err_n)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
      if (a == PCA) return DW'(m_pc);
      if (byp && w_en_ldr && (w_addr_ldr == a)) return w_data_ldr;
      if (byp && w_en1 && (w_addr1 == a)) return w_data1;
      return m_reg[a];
   endfunction

   function automatic logic m_busy_of(input logic [AW-1:0] a, input bit byp);
      if (a == PCA) return 1'b0;
      if (byp && w_en_ldr && (w_addr_ldr == a)) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NR; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
      m_pend = 0;
      m_err  = 1'b0;
      m_pc   = '0;
   endtask

   // Apply one clock edge worth of the rules to the model, using the inputs held this cycle.
   task automatic model_step();
      bit ready;
      ready = (m_pend < MP);
      if (w_en1 && (w_addr1 != PCA)) m_reg[w_addr1] = w_data1;
      if (w_en_ldr && (w_addr_ldr != PCA)) begin
         m_reg[w_addr_ldr] = w_data_ldr;
         if (m_busy[w_addr_ldr]) begin
            m_busy[w_addr_ldr] = 1'b0;
            m_pend--;
         end
      end
      if (ldr_issue) begin
         if (ready && (ldr_issue_addr != PCA) && !m_busy[ldr_issue_addr]) begin
            m_busy[ldr_issue_addr] = 1'b1;
            m_pend++;
         end else begin
            m_err = 1'b1;
         end
      end
      if (load_pc) begin
         case (sel_pc)
            2'b01:   m_pc = start_pc;
            2'b11:   m_pc = dp_pc;
            default: m_pc = m_pc + PW'(1);
         endcase
      end
   endtask

   task automatic check_outputs();
      logic [AW-1:0] a;
      for (int i = 0; i < NRD; i++) begin
         a = rd_addr[i*AW +: AW];
         chk($sformatf("rd_data_byp[%0d]", i), rd_data_b[i*DW +: DW], m_read(a, 1'b1));
         chk($sformatf("rd_data_nb[%0d]", i), rd_data_n[i*DW +: DW], m_read(a, 1'b0));
         chk($sformatf("rd_busy_byp[%0d]", i), rd_busy_b[i], m_busy_of(a, 1'b1));
         chk($sformatf("rd_busy_nb[%0d]", i), rd_busy_n[i], m_busy_of(a, 1'b0));
      end
      chk("issue_ready", issue_ready_b, (m_pend < MP));
      chk("pend_cnt", pend_cnt_b, m_pend);
      chk("sb_err", sb_err_b, m_err);
      chk("pc_out", pc_out_b, m_pc);
      chk("pend_cnt_nb", pend_cnt_n, m_pend);
      chk("sb_err_nb", sb_err_n, m_err);
      chk("pc_out_nb", pc_out_n, m_pc);
   endtask

   task automatic idle();
      w_en1 = 1'b0;  w_en_ldr = 1'b0;  ldr_issue = 1'b0;  load_pc = 1'b0;
      w_data1 = '0;  w_addr1 = '0;  w_data_ldr = '0;  w_addr_ldr = '0;
      ldr_issue_addr = '0;  sel_pc = 2'b00;  start_pc = '0;  dp_pc = '0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
      rd_addr = {a3, a2, a1, a0};
   endtask

   // Inputs are already driven (at a falling edge); check, clock, advance model.
   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      set_rd(4'd0, 4'd1, 4'd2, 4'd3);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      #1;
      chk("rst_pend", pend_cnt_b, 0);
      chk("rst_ready", issue_ready_b, 1);
      chk("rst_err", sb_err_b, 0);
      chk("rst_pc", pc_out_b, 0);
      chk("rst_busy", rd_busy_b, 0);

      // R3 write then read on all ports
      w_en1 = 1'b1; w_addr1 = 4'd3; w_data1 = 32'hDEADBEEF;
      set_rd(4'd3, 4'd3, 4'd3, 4'd3);
      step();
      idle(); #1;
      for (int i = 0; i < NRD; i++) begin
         chk("r3_byp", rd_data_b[i*DW +: DW], 32'hDEADBEEF);
         chk("r3_nb", rd_data_n[i*DW +: DW], 32'hDEADBEEF);
      end
      // write to PC index is ignored
      w_en1 = 1'b1; w_addr1 = PCA; w_data1 = 32'd5;
      set_rd(PCA, PCA, PCA, PCA);
      step();
      idle(); #1;
      chk("r15_read", rd_data_b[DW-1:0], 32'd0);
      chk("r15_read_nb", rd_data_n[3*DW +: DW], 32'd0);

      // same-cycle dual write to R2
      w_en1 = 1'b1; w_addr1 = 4'd2; w_data1 = 32'h11;
      w_en_ldr = 1'b1; w_addr_ldr = 4'd2; w_data_ldr = 32'h22;
      set_rd(4'd2, 4'd2, 4'd2, 4'd2);
      #1;
      chk("r2_same_byp", rd_data_b[DW-1:0], 32'h22);
      chk("r2_same_nb", rd_data_n[DW-1:0], 32'h0);
      step();
      idle(); #1;
      chk("r2_after", rd_data_n[DW-1:0], 32'h22);

      // fill the scoreboard
      for (int r = 1; r <= 4; r++) begin
         ldr_issue = 1'b1; ldr_issue_addr = AW'(r);
         step();
      end
      idle();
      set_rd(4'd1, 4'd2, 4'd3, 4'd4);
      #1;
      chk("full_pend", pend_cnt_b, 4);
      chk("full_ready", issue_ready_b, 0);
      chk("full_busy", rd_busy_b, 4'hF);
      ldr_issue = 1'b1; ldr_issue_addr = 4'd5;
      step();
      idle(); #1;
      chk("over_err", sb_err_b, 1);
      chk("over_pend", pend_cnt_b, 4);
      w_en_ldr = 1'b1; w_addr_ldr = 4'd2; w_data_ldr = 32'h55;
      step();
      idle(); #1;
      chk("wb_pend", pend_cnt_b, 3);
      chk("wb_ready", issue_ready_b, 1);

      // asynchronous reset mid-operation
      set_rd(4'd1, 4'd3, 4'd4, PCA);
      do_reset();
      #1;
      chk("mid_rst_pend", pend_cnt_b, 0);
      chk("mid_rst_err", sb_err_b, 0);
      chk("mid_rst_busy", rd_busy_b, 0);
      chk("mid_rst_rd", rd_data_b, '0);

      // clear and reissue of the same register in one cycle
      ldr_issue = 1'b1; ldr_issue_addr = 4'd6;
      step();
      idle();
      w_en_ldr = 1'b1; w_addr_ldr = 4'd6; w_data_ldr = 32'h77;
      ldr_issue = 1'b1; ldr_issue_addr = 4'd6;
      step();
      idle();
      set_rd(4'd6, 4'd6, 4'd6, 4'd6);
      #1;
      chk("r6_data", rd_data_b[DW-1:0], 32'h77);
      chk("r6_busy", rd_busy_b[0], 1);
      chk("r6_pend", pend_cnt_b, 1);
      chk("r6_err", sb_err_b, 0);

      // PC sequencing
      load_pc = 1'b1; sel_pc = 2'b01; start_pc = 7'h7E;
      step(); #1; chk("pc_start", pc_out_b, 7'h7E);
      sel_pc = 2'b00;
      step(); #1; chk("pc_inc1", pc_out_b, 7'h7F);
      sel_pc = 2'b10;
      step(); #1; chk("pc_wrap", pc_out_b, 7'h00);
      sel_pc = 2'b11; dp_pc = 7'h10;
      step(); #1; chk("pc_branch", pc_out_b, 7'h10);
      load_pc = 1'b0; sel_pc = 2'b01;
      step(); #1; chk("pc_hold", pc_out_b, 7'h10);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(99, 0) == 0) begin
            rd_addr = NRD*AW'($urandom);
            do_reset();
         end else begin
            bit found;
            int s;
            w_en1          = ($urandom_range(2, 0) == 0);
            w_addr1        = AW'($urandom);
            w_data1        = $urandom;
            w_en_ldr       = ($urandom_range(2, 0) == 0);
            w_addr_ldr     = AW'($urandom);
            w_data_ldr     = $urandom;
            if ($urandom_range(1, 0) == 1 && m_pend > 0) begin
               found = 1'b0;
               s = $urandom_range(NR - 1, 0);
               for (int k = 0; k < NR; k++) begin
                  if (!found && m_busy[(s + k) % NR]) begin
                     w_addr_ldr = AW'((s + k) % NR);
                     found = 1'b1;
                  end
               end
            end
            ldr_issue      = ($urandom_range(2, 0) == 0);
            ldr_issue_addr = AW'($urandom);
            load_pc        = ($urandom_range(3, 0) == 0);
            sel_pc         = 2'($urandom);
            start_pc       = PW'($urandom);
            dp_pc          = PW'($urandom);
            rd_addr        = NRD*AW'($urandom);
            if ($urandom_range(3, 0) == 0) begin
               rd_addr[AW-1:0] = w_addr_ldr;
               rd_addr[2*AW-1:AW] = w_addr1;
            end
            step();
         end
      end
      idle();
      #1;
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
